// File: rtl/decode_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : decode_seq                                                |
// | Purpose  : FETCH/EXEC1/EXECW/HALT phase sequencer, instruction       |
// |            register and ISA decoder for the 16-bit CPU. Produces     |
// |            register-file, PC, data-memory and stack strobes.         |
// | Option   : DECODE_WAIT_EN adds imem_ready/dmem_ready wait inputs.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module decode_seq #(
  parameter int NREG    = 8,
  parameter int LD_LAT  = 1,
  parameter int MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     instr,
  input  logic            cond_result,
`ifdef DECODE_WAIT_EN
  input  logic            imem_ready,
  input  logic            dmem_ready,
`endif
  output logic            imem_en,
  output logic [15:0]     ir,
  output logic            phase_fetch,
  output logic            phase_exec1,
  output logic            phase_final,
  output logic            halted,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [NREG-1:0] rf_we,
  output logic [2:0]      rs1_sel,
  output logic [2:0]      rs2_sel,
  output logic [2:0]      rd_sel,
  output logic            dmem_en,
  output logic            dmem_wren,
  output logic            stack_push,
  output logic            stack_pop,
  output logic            stack_rst
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXECW = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] C_LD_CNT  = 4'(LD_LAT - 1);
  localparam logic [3:0] C_MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic        imem_rdy, dmem_rdy;

`ifdef DECODE_WAIT_EN
  assign imem_rdy = imem_ready;
  assign dmem_rdy = dmem_ready;
`else
  assign imem_rdy = 1'b1;
  assign dmem_rdy = 1'b1;
`endif

  // Instruction field decode (only meaningful while executing)
  logic [5:0] op;
  logic       nm;
  logic       is_lda, is_sta, is_jmp, is_jma, is_jcx, is_mul, is_mla, is_mls;
  logic       is_psh, is_pop, is_ldr, is_str, is_cll, is_rtn, is_nop, is_stp;
  logic       is_ldc, is_mulc, is_alu;

  assign op      = ir_q[14:9];
  assign nm      = ~ir_q[15];
  assign is_lda  = ir_q[15] & ~ir_q[14];
  assign is_sta  = ir_q[15] &  ir_q[14];
  assign is_jmp  = nm & (op == 6'b000000);
  assign is_jma  = nm & (op == 6'b000001);
  assign is_jcx  = nm & ((op[5:2] == 4'b0001) | (op[5:2] == 4'b0010));
  assign is_mul  = nm & (op == 6'b011100);
  assign is_mla  = nm & (op == 6'b011101);
  assign is_mls  = nm & (op == 6'b011110);
  assign is_psh  = nm & (op == 6'b101000);
  assign is_pop  = nm & (op == 6'b101001);
  assign is_ldr  = nm & (op == 6'b101010);
  assign is_str  = nm & (op == 6'b101011);
  assign is_cll  = nm & (op == 6'b100110);
  assign is_rtn  = nm & (op == 6'b100111);
  assign is_nop  = nm & (op == 6'b111110);
  assign is_stp  = nm & (op == 6'b111111);
  assign is_ldc  = is_lda | is_ldr | is_pop | is_rtn;
  assign is_mulc = is_mul | is_mla | is_mls;
  assign is_alu  = nm & ~(is_jmp | is_jma | is_jcx | is_mulc | is_psh | is_pop |
                          is_ldr | is_str | is_cll | is_rtn | is_nop | is_stp);

  // Phase qualification; a data load waiting on dmem_ready is not yet final
  logic in_fetch, in_exec1, in_execw, in_halt, in_exec;
  logic wait_dmem, is_final;

  assign in_fetch  = (state_q == S_FETCH);
  assign in_exec1  = (state_q == S_EXEC1);
  assign in_execw  = (state_q == S_EXECW);
  assign in_halt   = (state_q == S_HALT);
  assign in_exec   = in_exec1 | in_execw;
  assign wait_dmem = (is_lda | is_ldr) & ~dmem_rdy;
  assign is_final  = (in_exec1 & ~(is_ldc | is_mulc)) |
                     (in_execw & (cnt_q == 4'd0) & ~wait_dmem);

  // Writeback target and strobes
  logic       wr_cls, wr_fire, we_pc;
  logic [2:0] wr_idx;

  assign wr_cls  = is_alu | is_mulc | is_pop | is_ldr | is_lda;
  assign wr_idx  = is_lda ? ir_q[13:11] : ir_q[8:6];
  assign wr_fire = is_final & wr_cls;
  assign we_pc   = wr_fire & (wr_idx == 3'd0);

  for (genvar i = 0; i < NREG; i++) begin : g_rf_we
    assign rf_we[i] = wr_fire & (wr_idx == 3'(i));
  end

  assign pc_load     = (in_exec1 & (is_jmp | is_jma | is_cll | (is_jcx & cond_result))) |
                       (is_final & is_rtn);
  assign pc_inc      = is_final & ~pc_load & ~we_pc & ~is_stp;
  assign dmem_en     = in_exec1 & (is_lda | is_sta | is_ldr | is_str);
  assign dmem_wren   = in_exec1 & (is_sta | is_str);
  assign stack_push  = in_exec1 & (is_psh | is_cll);
  assign stack_pop   = in_exec1 & (is_pop | is_rtn);
  assign stack_rst   = in_halt;
  assign halted      = in_halt;
  assign imem_en     = in_fetch;
  assign phase_fetch = in_fetch;
  assign phase_exec1 = in_exec1;
  assign phase_final = is_final;
  assign ir          = ir_q;

  // Register selects, held through EXECW so multi-cycle units see stable operands
  always_comb begin
    rs1_sel = 3'd0;
    rs2_sel = 3'd0;
    rd_sel  = 3'd0;
    if (in_exec) begin
      if (is_sta)
        rs1_sel = ir_q[13:11];
      else if (!(is_jmp | is_jma | is_nop | is_stp | is_pop | is_cll | is_rtn | is_lda))
        rs1_sel = ir_q[5:3];
      if (is_alu | is_mulc)
        rs2_sel = ir_q[2:0];
      if (!(is_sta | is_lda | is_nop | is_stp | is_psh | is_pop | is_rtn))
        rd_sel = ir_q[8:6];
    end
  end

  // Next-state, wait-counter and instruction-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (imem_rdy) begin
          ir_d    = instr;
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (is_ldc) begin
          cnt_d   = C_LD_CNT;
          state_d = S_EXECW;
        end else if (is_mulc) begin
          cnt_d   = C_MUL_CNT;
          state_d = S_EXECW;
        end else if (is_stp) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXECW: begin
        if (cnt_q != 4'd0)
          cnt_d = cnt_q - 4'd1;
        else if (!wait_dmem)
          state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_decode_seq                                             |
// | Purpose  : Self-checking bench for decode_seq: directed vector       |
// |            table, halt/reset sequences and random instructions       |
// |            checked against a per-instruction cycle-trace model.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_decode_seq;
  localparam int NREG    = 6;
  localparam int LD_LAT  = 2;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] instr = 16'd0;
  logic cond_result = 1'b0;
`ifdef DECODE_WAIT_EN
  logic imem_ready = 1'b1;
  logic dmem_ready = 1'b1;
`endif
  logic imem_en, phase_fetch, phase_exec1, phase_final, halted, pc_inc, pc_load;
  logic [15:0] ir;
  logic [NREG-1:0] rf_we;
  logic [2:0] rs1_sel, rs2_sel, rd_sel;
  logic dmem_en, dmem_wren, stack_push, stack_pop, stack_rst;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_seq #(.NREG(NREG), .LD_LAT(LD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .cond_result(cond_result),
`ifdef DECODE_WAIT_EN
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
`endif
    .imem_en(imem_en), .ir(ir), .phase_fetch(phase_fetch), .phase_exec1(phase_exec1),
    .phase_final(phase_final), .halted(halted), .pc_inc(pc_inc), .pc_load(pc_load),
    .rf_we(rf_we), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
    .dmem_en(dmem_en), .dmem_wren(dmem_wren), .stack_push(stack_push),
    .stack_pop(stack_pop), .stack_rst(stack_rst)
  );

  typedef struct packed {
    logic imem_en, pf, pe1, pfin, halted, srst, pc_inc, pc_load;
    logic [NREG-1:0] we;
    logic [2:0] rs1, rs2, rd;
    logic den, dwr, push, pop;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    logic cond;
    int cyc;
    logic [2:0] rs1, rs2, rd;
    logic [NREG-1:0] we;
    logic inc, ld, den, dwr, psh, pop;
  } vec_t;

  vec_t tbl[19];
  obs_t exp_q[$];
  obs_t reset_obs, halt_obs;

  function automatic obs_t sample();
    obs_t o;
    o.imem_en = imem_en;   o.pf = phase_fetch;  o.pe1 = phase_exec1; o.pfin = phase_final;
    o.halted = halted;     o.srst = stack_rst;  o.pc_inc = pc_inc;   o.pc_load = pc_load;
    o.we = rf_we;          o.rs1 = rs1_sel;     o.rs2 = rs2_sel;     o.rd = rd_sel;
    o.den = dmem_en;       o.dwr = dmem_wren;   o.push = stack_push; o.pop = stack_pop;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Mnemonic of an instruction word, straight from the opcode map
  function automatic string mnem(input logic [15:0] w);
    if (w[15]) return w[14] ? "STA" : "LDA";
    if (w[14:11] == 4'b0001 || w[14:11] == 4'b0010) return "JCX";
    case (w[14:9])
      6'b000000: return "JMP";
      6'b000001: return "JMA";
      6'b011100: return "MUL";
      6'b011101: return "MLA";
      6'b011110: return "MLS";
      6'b101000: return "PSH";
      6'b101001: return "POP";
      6'b101010: return "LDR";
      6'b101011: return "STR";
      6'b100110: return "CLL";
      6'b100111: return "RTN";
      6'b111110: return "NOP";
      6'b111111: return "STP";
      default:   return "ALU";
    endcase
  endfunction

  // Expected per-cycle outputs for one instruction, FETCH first
  task automatic build_trace(input logic [15:0] w, input logic c);
    string n;
    int extra, dest;
    logic [2:0] s1, s2, sd;
    logic early, late, mulc;
    obs_t e;
    n = mnem(w);
    mulc = (n == "MUL" || n == "MLA" || n == "MLS");
    extra = (n == "LDA" || n == "LDR" || n == "POP" || n == "RTN") ? LD_LAT : (mulc ? MUL_LAT : 0);
    dest = -1;
    if (n == "ALU" || mulc || n == "POP" || n == "LDR") dest = int'(w[8:6]);
    if (n == "LDA") dest = int'(w[13:11]);
    if (dest >= NREG) dest = -1;
    if (n == "STA") s1 = w[13:11];
    else if (n == "JMP" || n == "JMA" || n == "NOP" || n == "STP" || n == "POP" ||
             n == "CLL" || n == "RTN" || n == "LDA") s1 = 3'd0;
    else s1 = w[5:3];
    s2 = (n == "ALU" || mulc) ? w[2:0] : 3'd0;
    sd = (n == "STA" || n == "LDA" || n == "NOP" || n == "STP" || n == "PSH" ||
          n == "POP" || n == "RTN") ? 3'd0 : w[8:6];
    early = (n == "JMP" || n == "JMA" || n == "CLL" || (n == "JCX" && c));
    late  = (n == "RTN");
    e = '0; e.imem_en = 1'b1; e.pf = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k <= extra; k++) begin
      e = '0; e.rs1 = s1; e.rs2 = s2; e.rd = sd;
      if (k == 0) begin
        e.pe1 = 1'b1;
        e.pc_load = early;
        e.den = (n == "LDA" || n == "STA" || n == "LDR" || n == "STR");
        e.dwr = (n == "STA" || n == "STR");
        e.push = (n == "PSH" || n == "CLL");
        e.pop = (n == "POP" || n == "RTN");
      end
      if (k == extra) begin
        e.pfin = 1'b1;
        if (dest >= 0) e.we[dest] = 1'b1;
        if (late) e.pc_load = 1'b1;
        e.pc_inc = !(early || late) && dest != 0 && n != "STP";
      end
      exp_q.push_back(e);
    end
  endtask

  // Apply one table row starting in the current FETCH cycle
  task automatic run_row(input vec_t v, input int r);
    int n, fin_at;
    bit done;
    logic [2:0] s1, s2, sd;
    logic [NREG-1:0] we;
    logic inc, ld, den, dwr, ps, pp;
    logic [15:0] ir_seen;
    s1 = 0; s2 = 0; sd = 0; we = '0; inc = 0; ld = 0; den = 0; dwr = 0; ps = 0; pp = 0;
    ir_seen = 16'hxxxx; fin_at = -1; done = 0;
    instr = v.ins; cond_result = 1'($urandom); #1;
    n = 1;
    while (!done && n < 40) begin
      tick();
      instr = 16'($urandom);
      cond_result = (n == 1) ? v.cond : 1'($urandom);
      #1;
      if (phase_fetch) done = 1;
      else begin
        n++;
        if (phase_exec1) begin
          s1 = rs1_sel; s2 = rs2_sel; sd = rd_sel; ir_seen = ir;
        end
        if (phase_final) fin_at = n - 1;
        we |= rf_we; inc |= pc_inc; ld |= pc_load; den |= dmem_en;
        dwr |= dmem_wren; ps |= stack_push; pp |= stack_pop;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL row%0d timeout: no return to FETCH within 40 cycles", r);
    end
    chk($sformatf("row%0d.cycles", r), n, v.cyc);
    chk($sformatf("row%0d.final_at", r), fin_at, v.cyc - 1);
    chk($sformatf("row%0d.ir", r), ir_seen, v.ins);
    chk($sformatf("row%0d.rs1", r), s1, v.rs1);
    chk($sformatf("row%0d.rs2", r), s2, v.rs2);
    chk($sformatf("row%0d.rd", r), sd, v.rd);
    chk($sformatf("row%0d.rf_we", r), we, v.we);
    chk($sformatf("row%0d.pc_inc", r), inc, v.inc);
    chk($sformatf("row%0d.pc_load", r), ld, v.ld);
    chk($sformatf("row%0d.dmem_en", r), den, v.den);
    chk($sformatf("row%0d.dmem_wren", r), dwr, v.dwr);
    chk($sformatf("row%0d.push", r), ps, v.psh);
    chk($sformatf("row%0d.pop", r), pp, v.pop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         ins      cnd cyc rs1 rs2 rd  we     inc ld den dwr psh pop
    tbl[0]  = '{16'h2098, 1'b0, 2, 3'd3, 3'd0, 3'd2, 6'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'h394A, 1'b0, 5, 3'd1, 3'd2, 3'd5, 6'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{16'h9810, 1'b0, 4, 3'd0, 3'd0, 3'd0, 6'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'h0800, 1'b1, 2, 3'd0, 3'd0, 3'd0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h0800, 1'b0, 2, 3'd0, 3'd0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h1400, 1'b1, 2, 3'd0, 3'd0, 3'd0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{16'hE810, 1'b0, 2, 3'd5, 3'd0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{16'h50E1, 1'b0, 2, 3'd4, 3'd0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{16'h5338, 1'b0, 4, 3'd0, 3'd0, 3'd0, 6'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{16'h4C00, 1'b1, 2, 3'd0, 3'd0, 3'd0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{16'h4E00, 1'b0, 4, 3'd0, 3'd0, 3'd0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{16'h2000, 1'b0, 2, 3'd0, 3'd0, 3'd0, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{16'h21F5, 1'b0, 2, 3'd6, 3'd5, 3'd7, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{16'h5453, 1'b0, 4, 3'd2, 3'd0, 3'd1, 6'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{16'h5618, 1'b0, 2, 3'd3, 3'd0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{16'h0000, 1'b0, 2, 3'd0, 3'd0, 3'd0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{16'h02FF, 1'b0, 2, 3'd0, 3'd0, 3'd3, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{16'h7DFF, 1'b0, 2, 3'd0, 3'd0, 3'd0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{16'h3C2A, 1'b1, 5, 3'd5, 3'd2, 3'd0, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_obs = '0; reset_obs.imem_en = 1'b1; reset_obs.pf = 1'b1;
    halt_obs = '0;  halt_obs.halted = 1'b1;   halt_obs.srst = 1'b1;

    // Reset state
    #3;
    chk("reset.outputs", sample(), reset_obs);
    chk("reset.ir", ir, 16'h0000);
    #4 rst_n = 1'b1;

    // Directed table
    for (int r = 0; r < 19; r++) run_row(tbl[r], r);

    // STP enters HALT and stays there until reset
    instr = 16'h7E00; #1;
    tick(); #1;
    chk("stp.final", phase_final, 1'b1);
    chk("stp.pc_inc", pc_inc, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(); instr = 16'($urandom); cond_result = 1'($urandom); #1;
      chk($sformatf("halt.c%0d", k), sample(), halt_obs);
    end
    rst_n = 1'b0; #1;
    chk("halt_reset.outputs", sample(), reset_obs);
    #2 rst_n = 1'b1;

    // Reset asserted in the middle of a multiply wait aborts it
    instr = 16'h394A; #1;
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("mid_reset.outputs", sample(), reset_obs);
    chk("mid_reset.ir", ir, 16'h0000);
    tick(); #1;
    chk("mid_reset.held", sample(), reset_obs);
    rst_n = 1'b1;

`ifdef DECODE_WAIT_EN
    // FETCH holds while instruction memory is not ready
    imem_ready = 1'b0; instr = 16'h2098; #1;
    for (int k = 0; k < 3; k++) begin
      tick(); instr = 16'($urandom); #1;
      chk($sformatf("imem_hold%0d.fetch", k), phase_fetch, 1'b1);
      chk($sformatf("imem_hold%0d.ir", k), ir, 16'h0000);
    end
    imem_ready = 1'b1; instr = 16'h2098; #1;
    tick(); #1;
    chk("imem_go.ir", ir, 16'h2098);
    tick();
    // LDA final cycle waits for data memory
    dmem_ready = 1'b0; instr = 16'h9810; #1;
    tick(); tick(); tick(); #1;
    chk("dmem_hold.final", phase_final, 1'b0);
    chk("dmem_hold.we", rf_we, 6'h00);
    tick(); #1;
    chk("dmem_hold2.fetch", phase_fetch, 1'b0);
    chk("dmem_hold2.we", rf_we, 6'h00);
    dmem_ready = 1'b1; #1;
    chk("dmem_go.final", phase_final, 1'b1);
    chk("dmem_go.we", rf_we, 6'h08);
    tick();
`endif

    // Random instruction stream against the trace model
    for (int t = 0; t < 300; t++) begin
      logic [15:0] w;
      logic c;
      w = 16'($urandom);
      if (mnem(w) == "STP") w[9] = 1'b0;
      c = 1'($urandom);
      exp_q.delete();
      build_trace(w, c);
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k > 0) tick();
        instr = (k == 0) ? w : 16'($urandom);
        cond_result = (k == 1) ? c : 1'($urandom);
        #1;
        chk($sformatf("rnd%0d.c%0d(%h)", t, k, w), sample(), exp_q[k]);
        if (k == 1) chk($sformatf("rnd%0d.ir", t), ir, w);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
